// File: rtl/matmul_input_loader_pkg.sv
// -----------------------------------------------------------------------------
// matmul_input_loader_pkg
// Shared definitions for the matrix-multiplication input loader:
//   - default width parameters (also used by the matmul top)
//   - loader state encoding
//   - all-ones BRAM write-enable constant
// No ports (package).
// -----------------------------------------------------------------------------
package matmul_input_loader_pkg;

  // Width defaults shared with the matmul top.
  localparam int DEF_DWIDTH            = 8;
  localparam int DEF_AWIDTH            = 11;
  localparam int DEF_MAT_MUL_SIZE      = 8;
  localparam int DEF_MASK_WIDTH        = 8;
  localparam int DEF_ADDR_STRIDE_WIDTH = 8;
  localparam int DEF_CNT_WIDTH         = 8;
  localparam int DEF_ROW_WIDTH         = DEF_MAT_MUL_SIZE * DEF_DWIDTH;

  localparam logic [DEF_MASK_WIDTH-1:0] WE_ALL = {DEF_MASK_WIDTH{1'b1}};

  // Loader state encoding.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_KICK   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = S_IDLE,
    LOAD_A = S_LOAD_A,
    LOAD_B = S_LOAD_B,
    KICK   = S_KICK,
    DONE   = S_DONE
  } loader_state_t;

endpackage

// File: rtl/matmul_input_loader_if.sv
// -----------------------------------------------------------------------------
// matmul_input_loader_if
// Valid/ready row-word stream feeding the loader.
//   s_data  : row word payload (DATA_W bits)
//   s_valid : source has a word
//   s_ready : loader can take a word
// Modports: master = stream source, slave = loader.
// -----------------------------------------------------------------------------
interface matmul_input_loader_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/matmul_input_loader_skid_buffer.sv
// -----------------------------------------------------------------------------
// loader_skid_buffer
// Two-entry input buffer with a registered ready, used by the loader only when
// LOADER_INPUT_SKID_EN is defined (the whole module is compiled only then).
// Ports:
//   clk, resetn    : clock, asynchronous active-low reset
//   i_flush        : drop all buffered words
//   i_allow_next   : loader permits filling in the next cycle
//   i_valid/i_data : upstream word
//   i_pop          : consumer takes the head word when o_valid
//   o_ready        : registered ready toward upstream
//   o_valid/o_data : head word
// -----------------------------------------------------------------------------
`ifdef LOADER_INPUT_SKID_EN
module loader_skid_buffer #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_flush,
  input  logic             i_allow_next,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);
  logic [WIDTH-1:0] r_mem [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_fill;
  logic             r_ready;
  logic [1:0]       w_fill_next;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_valid && r_ready;
  assign w_pop   = i_pop && (r_fill != 2'd0);
  assign o_ready = r_ready;
  assign o_valid = (r_fill != 2'd0);
  assign o_data  = r_mem[r_rptr];

  always_comb begin
    w_fill_next = r_fill;
    if (i_flush) begin
      w_fill_next = 2'd0;
    end else begin
      w_fill_next = r_fill + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_fill  <= 2'd0;
      r_ready <= 1'b0;
    end else begin
      if (i_flush) begin
        r_wptr <= 1'b0;
        r_rptr <= 1'b0;
      end else begin
        if (w_push) r_wptr <= ~r_wptr;
        if (w_pop)  r_rptr <= ~r_rptr;
      end
      r_fill  <= w_fill_next;
      // Ready for next cycle: room left and the loader still wants words.
      r_ready <= i_allow_next && (w_fill_next != 2'd2);
    end
  end
endmodule
`endif

// File: rtl/matmul_input_loader.sv
// -----------------------------------------------------------------------------
// matmul_input_loader
// Accepts a valid/ready stream of row words and writes them through the
// external ports of BRAM A, then BRAM B, walking each matrix from its base
// address by a stride. After the last word, optionally pulses start_reg.
// Optional feature macro: LOADER_INPUT_SKID_EN (2-entry skid buffer on the
// stream, registered s_ready, write latency 2). Default: combinational s_ready.
// Ports:
//   clk, resetn                        : clock, asynchronous active-low reset
//   load_start                         : begin a load (IDLE/DONE only)
//   address_mat_a/b, address_stride_a/b, num_words_a/b, auto_start : load setup
//   s_if (slave)                       : row-word stream
//   bram_addr/wdata/we_{a,b}_ext       : BRAM external write ports
//   start_reg                          : one-cycle matmul start pulse
//   busy, load_done                    : status
// -----------------------------------------------------------------------------
module matmul_input_loader
  import matmul_input_loader_pkg::*;
#(
  parameter int DWIDTH            = DEF_DWIDTH,
  parameter int AWIDTH            = DEF_AWIDTH,
  parameter int MAT_MUL_SIZE      = DEF_MAT_MUL_SIZE,
  parameter int MASK_WIDTH        = DEF_MASK_WIDTH,
  parameter int ADDR_STRIDE_WIDTH = DEF_ADDR_STRIDE_WIDTH,
  parameter int CNT_WIDTH         = DEF_CNT_WIDTH
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             load_start,
  input  logic [AWIDTH-1:0]                address_mat_a,
  input  logic [AWIDTH-1:0]                address_mat_b,
  input  logic [ADDR_STRIDE_WIDTH-1:0]     address_stride_a,
  input  logic [ADDR_STRIDE_WIDTH-1:0]     address_stride_b,
  input  logic [CNT_WIDTH-1:0]             num_words_a,
  input  logic [CNT_WIDTH-1:0]             num_words_b,
  input  logic                             auto_start,
  matmul_input_loader_if.slave             s_if,
  output logic [AWIDTH-1:0]                bram_addr_a_ext,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0]   bram_wdata_a_ext,
  output logic [MASK_WIDTH-1:0]            bram_we_a_ext,
  output logic [AWIDTH-1:0]                bram_addr_b_ext,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0]   bram_wdata_b_ext,
  output logic [MASK_WIDTH-1:0]            bram_we_b_ext,
  output logic                             start_reg,
  output logic                             busy,
  output logic                             load_done
);
  localparam int RW = MAT_MUL_SIZE * DWIDTH;
  localparam logic [MASK_WIDTH-1:0] WE_ONES = {MASK_WIDTH{1'b1}};

  loader_state_t              r_state, w_state_next;
  logic [AWIDTH-1:0]          r_addr_a, r_addr_b;
  logic [ADDR_STRIDE_WIDTH-1:0] r_stride_a, r_stride_b;
  logic [CNT_WIDTH-1:0]       r_cnt, r_num_b;
  logic                       r_auto;
  logic [AWIDTH-1:0]          r_bram_addr_a, r_bram_addr_b;
  logic [RW-1:0]              r_bram_wdata_a, r_bram_wdata_b;
  logic [MASK_WIDTH-1:0]      r_we_a, r_we_b;
  logic                       w_in_load, w_load, w_take, w_last;
  logic [RW-1:0]              w_data;

  assign w_in_load = (r_state == LOAD_A) || (r_state == LOAD_B);
  assign w_load    = load_start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last    = w_take && (r_cnt == CNT_WIDTH'(1));

`ifdef LOADER_INPUT_SKID_EN
  logic               w_buf_valid, w_buf_ready, w_flush, w_allow_next, w_push;
  logic [RW-1:0]      w_buf_data;
  logic [CNT_WIDTH:0] r_acc, r_total, w_acc_next, w_total_next;

  // Accepted words are counted across both matrices so the buffer never
  // takes a word beyond the requested total.
  assign w_push       = s_if.s_valid && w_buf_ready;
  assign w_acc_next   = w_load ? '0 : r_acc + {{CNT_WIDTH{1'b0}}, w_push};
  assign w_total_next = w_load ? ({1'b0, num_words_a} + {1'b0, num_words_b}) : r_total;
  assign w_allow_next = ((w_state_next == LOAD_A) || (w_state_next == LOAD_B)) &&
                        (w_acc_next < w_total_next);
  assign w_flush      = (w_state_next == KICK) || (w_state_next == DONE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_acc   <= '0;
      r_total <= '0;
    end else begin
      r_acc   <= w_acc_next;
      r_total <= w_total_next;
    end
  end

  loader_skid_buffer #(.WIDTH(RW)) u_skid (
    .clk          (clk),
    .resetn       (resetn),
    .i_flush      (w_flush),
    .i_allow_next (w_allow_next),
    .i_valid      (s_if.s_valid),
    .i_data       (s_if.s_data),
    .i_pop        (w_in_load),
    .o_ready      (w_buf_ready),
    .o_valid      (w_buf_valid),
    .o_data       (w_buf_data)
  );

  assign s_if.s_ready = w_buf_ready;
  assign w_take       = w_buf_valid && w_in_load;
  assign w_data       = w_buf_data;
`else
  assign s_if.s_ready = w_in_load;
  assign w_take       = s_if.s_valid && w_in_load;
  assign w_data       = s_if.s_data;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (load_start) begin
          if (num_words_a != '0)      w_state_next = LOAD_A;
          else if (num_words_b != '0) w_state_next = LOAD_B;
          else                        w_state_next = DONE;
        end
      end
      LOAD_A: begin
        if (w_last) begin
          if (r_num_b != '0) w_state_next = LOAD_B;
          else               w_state_next = r_auto ? KICK : DONE;
        end
      end
      LOAD_B: begin
        if (w_last) w_state_next = r_auto ? KICK : DONE;
      end
      KICK:    w_state_next = DONE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state        <= IDLE;
      r_addr_a       <= '0;
      r_addr_b       <= '0;
      r_stride_a     <= '0;
      r_stride_b     <= '0;
      r_cnt          <= '0;
      r_num_b        <= '0;
      r_auto         <= 1'b0;
      r_bram_addr_a  <= '0;
      r_bram_addr_b  <= '0;
      r_bram_wdata_a <= '0;
      r_bram_wdata_b <= '0;
      r_we_a         <= '0;
      r_we_b         <= '0;
    end else begin
      r_state <= w_state_next;
      r_we_a  <= '0;
      r_we_b  <= '0;
      if (w_load) begin
        r_addr_a   <= address_mat_a;
        r_addr_b   <= address_mat_b;
        r_stride_a <= address_stride_a;
        r_stride_b <= address_stride_b;
        r_num_b    <= num_words_b;
        r_auto     <= auto_start;
        // Counter loads for whichever matrix is entered first.
        r_cnt      <= (num_words_a != '0) ? num_words_a : num_words_b;
      end else if (w_take) begin
        if (r_state == LOAD_A) begin
          r_bram_addr_a  <= r_addr_a;
          r_bram_wdata_a <= w_data;
          r_we_a         <= WE_ONES;
          r_addr_a       <= r_addr_a + AWIDTH'(r_stride_a);
          // Reload for B when the last A word goes out.
          r_cnt          <= w_last ? r_num_b : r_cnt - CNT_WIDTH'(1);
        end else begin
          r_bram_addr_b  <= r_addr_b;
          r_bram_wdata_b <= w_data;
          r_we_b         <= WE_ONES;
          r_addr_b       <= r_addr_b + AWIDTH'(r_stride_b);
          r_cnt          <= r_cnt - CNT_WIDTH'(1);
        end
      end
    end
  end

  assign bram_addr_a_ext  = r_bram_addr_a;
  assign bram_wdata_a_ext = r_bram_wdata_a;
  assign bram_we_a_ext    = r_we_a;
  assign bram_addr_b_ext  = r_bram_addr_b;
  assign bram_wdata_b_ext = r_bram_wdata_b;
  assign bram_we_b_ext    = r_we_b;
  assign start_reg        = (r_state == KICK);
  assign busy             = w_in_load || (r_state == KICK);
  assign load_done        = (r_state == DONE);

endmodule

// File: tb/tb_matmul_input_loader.sv
// -----------------------------------------------------------------------------
// tb_matmul_input_loader
// Directed bench for matmul_input_loader (default build, no skid buffer).
// -----------------------------------------------------------------------------
module tb_matmul_input_loader;
  logic        clk = 1'b0;
  logic        resetn;
  logic        load_start;
  logic [10:0] address_mat_a, address_mat_b;
  logic [7:0]  address_stride_a, address_stride_b;
  logic [7:0]  num_words_a, num_words_b;
  logic        auto_start;
  logic [10:0] bram_addr_a_ext, bram_addr_b_ext;
  logic [63:0] bram_wdata_a_ext, bram_wdata_b_ext;
  logic [7:0]  bram_we_a_ext, bram_we_b_ext;
  logic        start_reg, busy, load_done;

  int n_cmp = 0;
  int n_err = 0;

  logic [10:0] a_log[$];
  logic [63:0] a_dlog[$];
  logic [10:0] b_log[$];
  int          n_start = 0;

  matmul_input_loader_if #(.DATA_W(64)) s_if ();

  matmul_input_loader dut (
    .clk              (clk),
    .resetn           (resetn),
    .load_start       (load_start),
    .address_mat_a    (address_mat_a),
    .address_mat_b    (address_mat_b),
    .address_stride_a (address_stride_a),
    .address_stride_b (address_stride_b),
    .num_words_a      (num_words_a),
    .num_words_b      (num_words_b),
    .auto_start       (auto_start),
    .s_if             (s_if),
    .bram_addr_a_ext  (bram_addr_a_ext),
    .bram_wdata_a_ext (bram_wdata_a_ext),
    .bram_we_a_ext    (bram_we_a_ext),
    .bram_addr_b_ext  (bram_addr_b_ext),
    .bram_wdata_b_ext (bram_wdata_b_ext),
    .bram_we_b_ext    (bram_we_b_ext),
    .start_reg        (start_reg),
    .busy             (busy),
    .load_done        (load_done)
  );

  always #5 clk = ~clk;

  // Record every write and start pulse seen on the falling edge.
  always @(negedge clk) begin
    if (bram_we_a_ext != 8'h00) begin
      a_log.push_back(bram_addr_a_ext);
      a_dlog.push_back(bram_wdata_a_ext);
    end
    if (bram_we_b_ext != 8'h00) b_log.push_back(bram_addr_b_ext);
    if (start_reg) n_start++;
  end

  function automatic logic [63:0] word(input int i);
    return 64'hC0DE_0000_0000_0000 | 64'(i);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clear_logs();
    a_log.delete();
    a_dlog.delete();
    b_log.delete();
    n_start = 0;
  endtask

  // Call away from a clock edge; returns #1 after the edge that takes load_start.
  task automatic start_load(input logic [10:0] ba, input logic [7:0] sa, input logic [7:0] na,
                            input logic [10:0] bb, input logic [7:0] sb, input logic [7:0] nb,
                            input logic au);
    address_mat_a    = ba;
    address_stride_a = sa;
    num_words_a      = na;
    address_mat_b    = bb;
    address_stride_b = sb;
    num_words_b      = nb;
    auto_start       = au;
    load_start       = 1'b1;
    @(posedge clk);
    #1 load_start = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; load_start = 1'b0; auto_start = 1'b0;
    address_mat_a = '0; address_mat_b = '0;
    address_stride_a = '0; address_stride_b = '0;
    num_words_a = '0; num_words_b = '0;
    s_if.s_valid = 1'b0; s_if.s_data = '0;

    // Reset then idle.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_we_a", bram_we_a_ext, 8'h00);
    check("rst_we_b", bram_we_b_ext, 8'h00);
    check("rst_addr_a", bram_addr_a_ext, 11'h000);
    check("rst_start", start_reg, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", load_done, 1'b0);
    check("rst_ready", s_if.s_ready, 1'b0);
    @(posedge clk); #1 resetn = 1'b1;
    s_if.s_valid = 1'b1;
    @(negedge clk);
    check("idle_ready", s_if.s_ready, 1'b0);
    check("idle_busy", busy, 1'b0);
    s_if.s_valid = 1'b0;

    // Zero-length load from IDLE goes straight to DONE with nothing written.
    clear_logs();
    start_load(11'h010, 8'd8, 8'd0, 11'h100, 8'd8, 8'd0, 1'b1);
    @(negedge clk);
    check("zero_done", load_done, 1'b1);
    check("zero_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("zero_awr", a_log.size(), 0);
    check("zero_bwr", b_log.size(), 0);
    check("zero_start", n_start, 0);

    // Full A+B load with auto start, restarted from DONE.
    clear_logs();
    s_if.s_valid = 1'b1;
    s_if.s_data  = word(0);
    start_load(11'h010, 8'd8, 8'd3, 11'h100, 8'd8, 8'd2, 1'b1);
    @(negedge clk);
    check("t1_ready", s_if.s_ready, 1'b1);
    check("t1_busy", busy, 1'b1);
    check("t1_done0", load_done, 1'b0);
    check("t1_we0", bram_we_a_ext, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 s_if.s_data = word(i + 1);
      @(negedge clk);
      check("t1_we_a", bram_we_a_ext, 8'hFF);
      check("t1_addr_a", bram_addr_a_ext, 11'h010 + 11'(8 * i));
      check("t1_wdata_a", bram_wdata_a_ext, word(i));
      check("t1_we_b_idle", bram_we_b_ext, 8'h00);
      check("t1_start_a", start_reg, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1 s_if.s_data = word(i + 4);
      if (i == 1) s_if.s_valid = 1'b0;
      @(negedge clk);
      check("t1_we_b", bram_we_b_ext, 8'hFF);
      check("t1_addr_b", bram_addr_b_ext, 11'h100 + 11'(8 * i));
      check("t1_wdata_b", bram_wdata_b_ext, word(3 + i));
      check("t1_we_a_idle", bram_we_a_ext, 8'h00);
      check("t1_start_b", start_reg, (i == 1) ? 1'b1 : 1'b0);
    end
    check("t1_kick_busy", busy, 1'b1);
    check("t1_kick_ready", s_if.s_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("t1_done", load_done, 1'b1);
    check("t1_start_off", start_reg, 1'b0);
    check("t1_busy_off", busy, 1'b0);
    check("t1_we_b_off", bram_we_b_ext, 8'h00);
    check("t1_addr_b_hold", bram_addr_b_ext, 11'h108);
    check("t1_nstart", n_start, 1);
    check("t1_nawr", a_log.size(), 3);
    check("t1_nbwr", b_log.size(), 2);

    // Gapped stream, A only, no auto start.
    clear_logs();
    s_if.s_valid = 1'b0;
    start_load(11'h040, 8'd4, 8'd2, 11'h300, 8'd4, 8'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      s_if.s_valid = (k % 2 == 0);
      s_if.s_data  = word(10 + k);
      @(posedge clk); #1;
    end
    s_if.s_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("gap_nawr", a_log.size(), 2);
    if (a_log.size() == 2) begin
      check("gap_addr0", a_log[0], 11'h040);
      check("gap_addr1", a_log[1], 11'h044);
      check("gap_data0", a_dlog[0], word(10));
      check("gap_data1", a_dlog[1], word(12));
    end
    check("gap_nbwr", b_log.size(), 0);
    check("gap_nstart", n_start, 0);
    check("gap_done", load_done, 1'b1);

    // Address wrap-around.
    clear_logs();
    s_if.s_valid = 1'b1;
    s_if.s_data  = word(20);
    start_load(11'h7FC, 8'd8, 8'd2, 11'h100, 8'd8, 8'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1 s_if.s_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("wrap_nawr", a_log.size(), 2);
    if (a_log.size() == 2) begin
      check("wrap_addr0", a_log[0], 11'h7FC);
      check("wrap_addr1", a_log[1], 11'h004);
    end
    check("wrap_nstart", n_start, 0);
    check("wrap_done", load_done, 1'b1);

    // Reset after the first of four A words.
    clear_logs();
    s_if.s_valid = 1'b1;
    s_if.s_data  = word(30);
    start_load(11'h200, 8'd1, 8'd4, 11'h300, 8'd1, 8'd4, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("mid_we_a", bram_we_a_ext, 8'hFF);
    check("mid_addr_a", bram_addr_a_ext, 11'h200);
    #2 resetn = 1'b0;
    #1;
    check("arst_we_a", bram_we_a_ext, 8'h00);
    check("arst_addr_a", bram_addr_a_ext, 11'h000);
    check("arst_wdata_a", bram_wdata_a_ext, 64'h0);
    check("arst_busy", busy, 1'b0);
    check("arst_ready", s_if.s_ready, 1'b0);
    check("arst_done", load_done, 1'b0);
    clear_logs();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("post_nawr", a_log.size(), 0);
    check("post_nbwr", b_log.size(), 0);
    check("post_nstart", n_start, 0);
    check("post_busy", busy, 1'b0);
    check("post_done", load_done, 1'b0);
    check("post_ready", s_if.s_ready, 1'b0);
    s_if.s_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
